// File: rtl/reg_file.sv
// 32 x 32-bit register file with r0 hardwired to zero and a saturating write counter.
// Optional same-cycle write-through bypass on both read ports: define REG_FILE_WR_BYPASS_EN.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [15:0]       wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en_c;

  // Writes to r0 are dropped and do not count as committed.
  assign wr_en_c = we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_en_c) begin
      mem[rd_addr] <= rd_data;
      if (wr_count != '1) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Combinational read ports; zero while in reset or when addressing r0.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rst_n) begin
      if (rs_addr != '0) rs_data = mem[rs_addr];
      if (rt_addr != '0) rt_data = mem[rt_addr];
`ifdef REG_FILE_WR_BYPASS_EN
      if (wr_en_c && (rs_addr == rd_addr)) rs_data = rd_data;
      if (wr_en_c && (rt_addr == rd_addr)) rt_data = rd_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
// Expectations follow REG_FILE_WR_BYPASS_EN when the macro is defined.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [32];
  int          model_cnt;

  reg_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    model_cnt = 0;
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      model_mem[a] = d;
      if (model_cnt < 65535) model_cnt = model_cnt + 1;
    end
  endfunction

  // What a read port must show before the edge, given the current write request.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_WR_BYPASS_EN
    if (w && wa != 5'd0 && wa == a) return wd;
`endif
    return model_mem[a];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; rd_addr = a; rd_data = d;
    @(posedge clk); #1;
    we = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_rd(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    n_checks++;
    if (wr_count !== 16'(model_cnt)) begin
      n_fail++;
      $display("FAIL %s: wr_count got %h expected %h", name, wr_count, 16'(model_cnt));
    end
  endtask

  task automatic test_reset();
    logic bad;
    do_write(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5;
    #1;
    check_rd("pre_reset_r5", rs_data, 32'hDEADBEEF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_rd("reset_r5", rs_data, 32'h0);
    check_cnt("reset_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bad = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(i);
      #1;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_all_zero: some register nonzero after reset, expected 0");
    end
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'h0000_0007);
    do_write(5'd4, 32'hFFFF_FFF9);
    rs_addr = 5'd3; rt_addr = 5'd4;
    #1;
    check_rd("basic_rs", rs_data, 32'h7);
    check_rd("basic_rt", rt_data, 32'hFFFF_FFF9);
    check_cnt("basic_cnt");
  endtask

  task automatic test_r0();
    do_write(5'd0, 32'h1234_5678);
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check_rd("r0_rs", rs_data, 32'h0);
    check_rd("r0_rt", rt_data, 32'h0);
    check_cnt("r0_cnt");
  endtask

  task automatic test_dual_read();
    do_write(5'd7, 32'hA5A5_A5A5);
    rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
    check_rd("dual_rs", rs_data, 32'hA5A5_A5A5);
    check_rd("dual_rt", rt_data, 32'hA5A5_A5A5);
  endtask

  task automatic test_hazard();
    do_write(5'd9, 32'h1);
    @(negedge clk);
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'h2; rs_addr = 5'd9; rt_addr = 5'd3;
    #1;
`ifdef REG_FILE_WR_BYPASS_EN
    check_rd("hazard_before", rs_data, 32'h2);
`else
    check_rd("hazard_before", rs_data, 32'h1);
`endif
    check_rd("hazard_other_port", rt_data, model_mem[3]);
    @(posedge clk); #1;
    we = 1'b0;
    model_write(5'd9, 32'h2);
    #1;
    check_rd("hazard_after", rs_data, 32'h2);
    check_cnt("hazard_cnt");
  endtask

  task automatic test_random();
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        w;
    int          bad_rd;
    int          bad_cnt;
    bad_rd = 0; bad_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      w  = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      we = w; rd_addr = wa; rd_data = wd;
      rs_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      n_checks++;
      if (rs_data !== model_read(rs_addr, w, wa, wd) ||
          rt_data !== model_read(rt_addr, w, wa, wd)) begin
        n_fail++;
        if (bad_rd < 5)
          $display("FAIL rand_read[%0d]: rs=%h rt=%h expected rs=%h rt=%h", k, rs_data, rt_data,
                   model_read(rs_addr, w, wa, wd), model_read(rt_addr, w, wa, wd));
        bad_rd++;
      end
      @(posedge clk); #1;
      if (w) model_write(wa, wd);
      n_checks++;
      if (wr_count !== 16'(model_cnt)) begin
        n_fail++;
        if (bad_cnt < 5)
          $display("FAIL rand_cnt[%0d]: wr_count got %h expected %h", k, wr_count, 16'(model_cnt));
        bad_cnt++;
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    n = 65534 - model_cnt;
    @(negedge clk);
    we = 1'b1; rd_addr = 5'd1; rd_data = 32'hCAFE_0001;
    repeat (n) @(posedge clk);
    #1;
    we = 1'b0;
    model_cnt = model_cnt + n;
    model_mem[1] = 32'hCAFE_0001;
    check_cnt("sat_fffe");
    do_write(5'd2, 32'h11);
    check_cnt("sat_ffff_1");
    do_write(5'd2, 32'h22);
    check_cnt("sat_hold_2");
    do_write(5'd2, 32'h33);
    check_cnt("sat_hold_3");
    n_checks++;
    if (wr_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_const: wr_count got %h expected ffff", wr_count);
    end
    rs_addr = 5'd2; rt_addr = 5'd1;
    #1;
    check_rd("sat_data_r2", rs_data, 32'h33);
    check_rd("sat_data_r1", rt_data, 32'hCAFE_0001);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; rd_addr = '0; rd_data = '0; rs_addr = '0; rt_addr = '0;
    model_reset();
    #1;
    check_rd("init_rs", rs_data, 32'h0);
    check_cnt("init_cnt");
    #12;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_r0();
    test_dual_read();
    test_hazard();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
